// File: rtl/count_reg_arbiter.sv
// count_reg_arbiter: round-robin arbiter sequencing load/add/sub/clear ops onto a shared count register
module count_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         op,
  input  logic [WIDTH*N_REQ-1:0]     wdata,
  input  logic                       ovf_clr,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           q,
  output logic                       upd,
  output logic [$clog2(N_REQ)-1:0]   upd_id,
  output logic                       ovf
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0]    ptr, gid, nptr;
  logic [IW:0]      s;
  logic             hit, set;
  logic [1:0]       gop;
  logic [WIDTH-1:0] wd, nxt;
  logic [WIDTH:0]   sum, dif;
  // first requesting index at or after ptr, wrapping; reset suppresses any grant
  always_comb begin
    hit = 1'b0;
    gid = '0;
    s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      s = (s >= (IW+1)'(N_REQ)) ? s - (IW+1)'(N_REQ) : s;
      if (!hit && !rst && req[s[IW-1:0]]) begin
        hit = 1'b1;
        gid = s[IW-1:0];
      end
    end
  end
  assign gnt  = hit ? (N_REQ'(1) << gid) : '0;
  assign gop  = op[2*gid +: 2];
  assign wd   = wdata[WIDTH*gid +: WIDTH];
  assign sum  = {1'b0, q} + {1'b0, wd};
  assign dif  = {1'b0, q} - {1'b0, wd};
  assign nxt  = gop == 2'd0 ? wd : gop == 2'd1 ? sum[WIDTH-1:0] : gop == 2'd2 ? dif[WIDTH-1:0] : '0;
  assign set  = hit & ((gop == 2'd1 & sum[WIDTH]) | (gop == 2'd2 & dif[WIDTH]));
  assign nptr = (gid == IW'(N_REQ-1)) ? '0 : gid + 1'b1;
  // register update on grant; a same-cycle overflow beats ovf_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      ptr    <= '0;
      upd    <= 1'b0;
      upd_id <= '0;
      ovf    <= 1'b0;
    end else begin
      upd <= hit;
      ovf <= set | (ovf & ~ovf_clr);
      if (hit) begin
        q      <= nxt;
        ptr    <= nptr;
        upd_id <= gid;
      end
    end
  end
endmodule

// File: tb/tb_count_reg_arbiter.sv
// tb_count_reg_arbiter: directed stimulus checked against a behavioural model and literal expectations
module tb_count_reg_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  op = '0;
  logic [47:0] wdata = '0;
  logic        ovf_clr = 1'b0;
  logic [3:0]  gnt;
  logic [11:0] q;
  logic        upd;
  logic [1:0]  upd_id;
  logic        ovf;
  int checks = 0;
  int failures = 0;

  count_reg_arbiter #(.N_REQ(4), .WIDTH(12)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata), .ovf_clr(ovf_clr),
    .gnt(gnt), .q(q), .upd(upd), .upd_id(upd_id), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ops(input logic [1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [47:0] wds(input logic [11:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model state: register value, priority pointer, last update, sticky flag
  int mq = 0, mptr = 0, mid = 0, nq, nptr, nid, eg, o, w, s;
  bit mupd = 0, movf = 0, nupd, novf, setf;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      eg = -1;
      if (!rst)
        for (int k = 0; k < 4; k++)
          if (eg < 0 && req[(mptr + k) % 4]) eg = (mptr + k) % 4;
      chk("model_gnt", gnt, (eg < 0) ? 0 : (1 << eg));
      chk("model_q", q, mq);
      chk("model_upd", upd, mupd);
      chk("model_ovf", ovf, movf);
      if (mupd) chk("model_upd_id", upd_id, mid);
      nq = mq; nptr = mptr; nid = mid; nupd = 0; setf = 0;
      if (eg >= 0) begin
        o = int'(op[2*eg +: 2]);
        w = int'(wdata[12*eg +: 12]);
        case (o)
          0: nq = w;
          1: begin s = mq + w; setf = s > 4095; nq = s % 4096; end
          2: begin setf = w > mq; nq = (mq - w + 4096) % 4096; end
          default: nq = 0;
        endcase
        nptr = (eg + 1) % 4; nid = eg; nupd = 1;
      end
      novf = setf || (movf && !ovf_clr);
      if (rst) begin nq = 0; nptr = 0; nid = 0; nupd = 0; novf = 0; end
      @(posedge clk);
      mq = nq; mptr = nptr; mid = nid; mupd = nupd; movf = novf;
    end
  end

  initial begin
    tick(); tick();
    chk("rst_q", q, 12'h000);
    chk("rst_upd", upd, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_gnt", gnt, 4'b0000);
    req = 4'b1111;
    #1 chk("rst_hold_gnt", gnt, 4'b0000);
    tick();
    chk("rst_hold_q", q, 12'h000);
    rst = 1'b0; req = '0;
    tick();
    req = 4'b0100; op = ops(2'd0, 2'd0, 2'd0, 2'd0); wdata = wds(0, 0, 12'h100, 0);
    #1 chk("single_gnt", gnt, 4'b0100);
    tick();
    chk("single_load", q, 12'h100);
    chk("single_id", upd_id, 2'd2);
    op = ops(2'd0, 2'd0, 2'd1, 2'd0); wdata = wds(0, 0, 12'h023, 0);
    tick();
    chk("single_add", q, 12'h123);
    op = ops(2'd0, 2'd0, 2'd2, 2'd0); wdata = wds(0, 0, 12'h003, 0);
    tick();
    chk("single_sub", q, 12'h120);
    op = ops(2'd0, 2'd0, 2'd3, 2'd0); wdata = wds(0, 0, 12'h555, 0);
    tick();
    chk("single_clear", q, 12'h000);
    chk("single_upd", upd, 1'b1);
    req = '0; rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111; op = '0; wdata = wds(12'h011, 12'h022, 12'h033, 12'h044);
    for (int k = 0; k < 8; k++) begin
      #1 chk("fair_gnt", gnt, 4'b0001 << (k % 4));
      tick();
    end
    chk("fair_last_q", q, 12'h044);
    req = 4'b0010;
    #1 chk("skip_g1", gnt, 4'b0010);
    tick();
    req = 4'b0001;
    #1 chk("skip_g0", gnt, 4'b0001);
    tick();
    req = 4'b1011;
    #1 chk("skip_ptr1", gnt, 4'b0010);
    tick();
    req = 4'b0001; op = ops(2'd0, 2'd0, 2'd0, 2'd0); wdata = wds(12'hFFF, 0, 0, 0);
    tick();
    chk("ovf_load", q, 12'hFFF);
    op = ops(2'd1, 2'd0, 2'd0, 2'd0); wdata = wds(12'h002, 0, 0, 0);
    tick();
    chk("ovf_add_q", q, 12'h001);
    chk("ovf_add_f", ovf, 1'b1);
    op = ops(2'd2, 2'd0, 2'd0, 2'd0); wdata = wds(12'h005, 0, 0, 0);
    tick();
    chk("ovf_sub_q", q, 12'hFFC);
    chk("ovf_sub_f", ovf, 1'b1);
    req = '0; ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", ovf, 1'b0);
    chk("ovf_clr_q", q, 12'hFFC);
    req = 4'b0001; op = ops(2'd1, 2'd0, 2'd0, 2'd0); wdata = wds(12'h010, 0, 0, 0);
    tick();
    chk("ovf_set_wins", ovf, 1'b1);
    chk("ovf_set_q", q, 12'h00C);
    ovf_clr = 1'b0; op = ops(2'd0, 2'd0, 2'd0, 2'd0); wdata = wds(12'h005, 0, 0, 0);
    tick();
    chk("ovf_load_keeps", ovf, 1'b1);
    req = 4'b1001; op = ops(2'd1, 2'd0, 2'd0, 2'd1); wdata = wds(12'h001, 0, 0, 12'h001);
    tick(); tick();
    chk("mid_q", q, 12'h007);
    rst = 1'b1;
    #1 chk("mid_rst_gnt", gnt, 4'b0000);
    tick();
    chk("mid_rst_q", q, 12'h000);
    chk("mid_rst_ovf", ovf, 1'b0);
    chk("mid_rst_upd", upd, 1'b0);
    rst = 1'b0;
    #1 chk("mid_first_gnt", gnt, 4'b0001);
    tick();
    chk("mid_first_q", q, 12'h001);
    chk("mid_first_id", upd_id, 2'd0);
    req = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
